// File: rtl/jk_pkg.sv
// Shared types and constants for the JK excitation driver.
// Holds the FSM state encoding and the per-bit J/K input codes.
package jk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        DONE  = 2'd2
    } state_t;

    // {J,K} excitation codes for one flip-flop
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_step_select.sv
// Priority select of the lowest STEP set bits of a vector, LSB first.
// Ports: vec_i (candidate bits), mask_o (selected subset of vec_i).
module jk_step_select #(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [WIDTH-1:0] mask_o
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0] cnt;

    // Running count of bits already taken; later bits are dropped
    // once the per-cycle budget is used up.
    always_comb begin
        mask_o = '0;
        cnt    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i] && (cnt < CW'(STEP))) begin
                mask_o[i] = 1'b1;
                cnt       = cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/jk_excitation_driver.sv
// Drives a JK register bank toward a target word, STEP bits per cycle.
// Ports: clk/reset, tgt_valid/tgt_ready/tgt_data handshake in,
//        j_out/k_out excitation, q bank model, busy, done pulse.
module jk_excitation_driver
    import jk_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sel;

    assign diff = q_q ^ tgt_q;
    assign q    = q_q;

    jk_step_select #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_sel (
        .vec_i  (diff),
        .mask_o (sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        tgt_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        j_out     = '0;
        k_out     = '0;
        unique case (state_q)
            IDLE: begin
                tgt_ready = 1'b1;
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    state_d = (tgt_data == q_q) ? DONE : APPLY;
                end
            end
            APPLY: begin
                busy  = 1'b1;
                j_out = sel & tgt_q;
                k_out = sel & ~tgt_q;
                // All remaining differences covered this cycle
                state_d = (sel == diff) ? DONE : APPLY;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bank model: JK rule per bit. Toggle is never driven but kept
    // so the model matches a real JK flip-flop.
    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({j_out[i], k_out[i]})
                JK_HOLD: q_d[i] = q_q[i];
                JK_RST:  q_d[i] = 1'b0;
                JK_SET:  q_d[i] = 1'b1;
                JK_TGL:  q_d[i] = ~q_q[i];
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed vector bench for jk_excitation_driver (STEP=2 and STEP=8).
// Inputs driven on the falling edge; outputs checked 1 ns later.
module tb_jk_excitation_driver;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    typedef struct {
        bit         chk;
        bit         rst;
        bit         vld;
        logic [7:0] data;
        bit         rdy;
        bit         bsy;
        bit         dn;
        logic [7:0] j;
        logic [7:0] k;
        logic [7:0] q;
    } vec_t;

    logic       clk;
    logic       rst_a, vld_a, rdy_a, bsy_a, dn_a;
    logic [7:0] dat_a, j_a, k_a, q_a;
    logic       rst_b, vld_b, rdy_b, bsy_b, dn_b;
    logic [7:0] dat_b, j_b, k_b, q_b;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    jk_excitation_driver #(.WIDTH(8), .STEP(2)) dut_a (
        .clk       (clk),
        .reset     (rst_a),
        .tgt_valid (vld_a),
        .tgt_ready (rdy_a),
        .tgt_data  (dat_a),
        .j_out     (j_a),
        .k_out     (k_a),
        .q         (q_a),
        .busy      (bsy_a),
        .done      (dn_a)
    );

    jk_excitation_driver #(.WIDTH(8), .STEP(8)) dut_b (
        .clk       (clk),
        .reset     (rst_b),
        .tgt_valid (vld_b),
        .tgt_ready (rdy_b),
        .tgt_data  (dat_b),
        .j_out     (j_b),
        .k_out     (k_b),
        .q         (q_b),
        .busy      (bsy_b),
        .done      (dn_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input bit c, input bit r, input bit v,
                       input logic [7:0] d, input bit rd, input bit b,
                       input bit dn, input logic [7:0] j,
                       input logic [7:0] k, input logic [7:0] qq);
        vec_t e;
        e.chk = c; e.rst = r; e.vld = v; e.data = d;
        e.rdy = rd; e.bsy = b; e.dn = dn;
        e.j = j; e.k = k; e.q = qq;
        tbl.push_back(e);
    endtask

    initial begin
        rst_a = 1'b1; vld_a = 1'b0; dat_a = 8'h00;
        rst_b = 1'b1; vld_b = 1'b0; dat_b = 8'h00;

        //  chk rst vld data   rdy bsy dn  j      k      q
        // reset held two cycles
        add(N, Y, N, 8'h00, Y, N, N, 8'h00, 8'h00, 8'h00);
        add(Y, Y, N, 8'h00, Y, N, N, 8'h00, 8'h00, 8'h00);
        // 0x00 -> 0x0F
        add(Y, N, Y, 8'h0F, Y, N, N, 8'h00, 8'h00, 8'h00);
        add(Y, N, N, 8'h00, N, Y, N, 8'h03, 8'h00, 8'h00);
        add(Y, N, N, 8'h00, N, Y, N, 8'h0C, 8'h00, 8'h03);
        add(Y, N, N, 8'h00, N, Y, Y, 8'h00, 8'h00, 8'h0F);
        // 0x0F -> 0xF0, done 5 cycles after accept
        add(Y, N, Y, 8'hF0, Y, N, N, 8'h00, 8'h00, 8'h0F);
        add(Y, N, N, 8'h00, N, Y, N, 8'h00, 8'h03, 8'h0F);
        add(Y, N, N, 8'h00, N, Y, N, 8'h00, 8'h0C, 8'h0C);
        add(Y, N, N, 8'h00, N, Y, N, 8'h30, 8'h00, 8'h00);
        add(Y, N, N, 8'h00, N, Y, N, 8'hC0, 8'h00, 8'h30);
        add(Y, N, N, 8'h00, N, Y, Y, 8'h00, 8'h00, 8'hF0);
        // target equal to q
        add(Y, N, Y, 8'hF0, Y, N, N, 8'h00, 8'h00, 8'hF0);
        add(Y, N, N, 8'h00, N, Y, Y, 8'h00, 8'h00, 8'hF0);
        // reset, then 0x00 -> 0xFF abandoned in 2nd APPLY cycle
        add(Y, Y, N, 8'h00, Y, N, N, 8'h00, 8'h00, 8'hF0);
        add(Y, N, Y, 8'hFF, Y, N, N, 8'h00, 8'h00, 8'h00);
        add(Y, N, N, 8'h00, N, Y, N, 8'h03, 8'h00, 8'h00);
        add(Y, Y, N, 8'h00, N, Y, N, 8'h0C, 8'h00, 8'h03);
        // back in IDLE, no done; accept 0x03
        add(Y, N, Y, 8'h03, Y, N, N, 8'h00, 8'h00, 8'h00);
        // 0x55 offered while busy is ignored
        add(Y, N, Y, 8'h55, N, Y, N, 8'h03, 8'h00, 8'h00);
        add(Y, N, Y, 8'h55, N, Y, Y, 8'h00, 8'h00, 8'h03);
        // now accepted: diff 0x56
        add(Y, N, Y, 8'h55, Y, N, N, 8'h00, 8'h00, 8'h03);
        add(Y, N, N, 8'h00, N, Y, N, 8'h04, 8'h02, 8'h03);
        add(Y, N, N, 8'h00, N, Y, N, 8'h50, 8'h00, 8'h05);
        add(Y, N, N, 8'h00, N, Y, Y, 8'h00, 8'h00, 8'h55);
        add(Y, N, N, 8'h00, Y, N, N, 8'h00, 8'h00, 8'h55);

        foreach (tbl[i]) begin
            @(negedge clk);
            rst_a = tbl[i].rst;
            vld_a = tbl[i].vld;
            dat_a = tbl[i].data;
            #1;
            if (tbl[i].chk) begin
                chk("ready", i, 8'(rdy_a), 8'(tbl[i].rdy));
                chk("busy",  i, 8'(bsy_a), 8'(tbl[i].bsy));
                chk("done",  i, 8'(dn_a),  8'(tbl[i].dn));
                chk("j_out", i, j_a, tbl[i].j);
                chk("k_out", i, k_a, tbl[i].k);
                chk("q",     i, q_a, tbl[i].q);
            end
        end

        // STEP=WIDTH: whole word in a single APPLY cycle
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b1;
        @(negedge clk); rst_b = 1'b0; vld_b = 1'b1; dat_b = 8'hA5;
        #1;
        chk("b_ready", 0, 8'(rdy_b), 8'h01);
        chk("b_q", 0, q_b, 8'h00);
        @(negedge clk); vld_b = 1'b0;
        #1;
        chk("b_busy", 1, 8'(bsy_b), 8'h01);
        chk("b_done", 1, 8'(dn_b), 8'h00);
        chk("b_j", 1, j_b, 8'hA5);
        chk("b_k", 1, k_b, 8'h00);
        @(negedge clk);
        #1;
        chk("b_done", 2, 8'(dn_b), 8'h01);
        chk("b_q", 2, q_b, 8'hA5);
        chk("b_j", 2, j_b, 8'h00);
        @(negedge clk);
        #1;
        chk("b_done", 3, 8'(dn_b), 8'h00);
        chk("b_ready", 3, 8'(rdy_b), 8'h01);
        chk("b_q", 3, q_b, 8'hA5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
